// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: major opcodes, immediate formats and bundle layout.
package decode_pipe_pkg;

    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_OP32    = 5'b01110;
    localparam logic [4:0] OPC_MISCMEM = 5'b00011;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

    // Bundle = {opcode, alu_op, rd, rs1, rs2, illegal, uses_rs1, uses_rs2, writes_rd, imm}.
    // The fixed part is 5*5 + 4 bits; the immediate adds XLEN bits on the low end.
    localparam int BUNDLE_FIXED_W = 29;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Immediate format is a pure function of the major opcode.
    function automatic imm_fmt_e imm_format(input logic [4:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
            OPC_JAL:                                    fmt = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: fmt = IMM_I;
            OPC_BRANCH:                                 fmt = IMM_B;
            OPC_STORE:                                  fmt = IMM_S;
            default:                                    fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RISC-V decoder producing the packed decode bundle.
module decode_comb
    import decode_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]                    insn,
    output logic [XLEN+BUNDLE_FIXED_W-1:0] bundle
);

    localparam bit RV64 = (XLEN == 64);

    logic [4:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        alu_op;
    logic              is_store;
    logic              is_branch;
    logic              is_op;
    logic              is_opimm;
    logic              shift_f3;
    logic              word_op;
    logic              alt;
    logic              illegal;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              writes_rd;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm;

    assign opcode    = insn[6:2];
    assign funct3    = insn[14:12];
    assign funct7    = insn[31:25];
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_op     = (opcode == OPC_OP) || (opcode == OPC_OP32);
    assign is_opimm  = (opcode == OPC_OPIMM) || (opcode == OPC_OPIMM32);
    assign shift_f3  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign word_op   = (opcode == OPC_OPIMM32) || (opcode == OPC_OP32);
    assign alt       = (is_op || (is_opimm && shift_f3)) ? insn[30] : 1'b0;
    assign alu_op    = {word_op, alt, funct3};
    assign rd        = (is_store || is_branch) ? 5'd0 : insn[11:7];

    // Every immediate format fits in 32 bits, so build it there and sign-extend to XLEN.
    always_comb begin
        imm32 = '0;
        case (imm_format(opcode))
            IMM_I:   imm32 = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   imm32 = {insn[31:12], 12'b0};
            IMM_J:   imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'(imm32);
    end

    // Illegal-instruction detection: reserved encodings and RV64-only forms on RV32.
    always_comb begin
        illegal = (insn[1:0] != 2'b11);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISCMEM, OPC_SYSTEM: begin
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b111) illegal = 1'b1;
                if (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110)) illegal = 1'b1;
            end
            OPC_STORE: begin
                if (funct3[2]) illegal = 1'b1;
                if (!RV64 && funct3 == 3'b011) illegal = 1'b1;
            end
            OPC_OPIMM: begin
                if (!RV64 && shift_f3 && insn[25]) illegal = 1'b1;
            end
            OPC_OP: begin
                if (funct7 != 7'b0000000 &&
                    !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    illegal = 1'b1;
            end
            OPC_OPIMM32, OPC_OP32: begin
                if (!RV64) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Usage flags for hazard logic; illegal instructions claim no registers.
    assign uses_rs1  = !illegal && !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign uses_rs2  = !illegal && (is_op || is_store || is_branch);
    assign writes_rd = !illegal && !is_store && !is_branch && (insn[11:7] != 5'd0);

    assign bundle = {opcode, alu_op, rd, insn[19:15], insn[24:20],
                     illegal, uses_rs1, uses_rs2, writes_rd, imm};

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage with valid/ready handshake, 2-entry skid buffer and flush.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_opcode,
    output logic [4:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic            out_writes_rd
);

    localparam int BW = XLEN + BUNDLE_FIXED_W;

    logic [BW-1:0]   dec_bundle;
    logic [BW-1:0]   main_bundle;
    logic [BW-1:0]   skid_bundle;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] skid_pc;
    logic            main_valid;
    logic            skid_valid;
    logic            in_ready_q;
    logic            accept;
    logic            main_free;
    logic            main_load;
    logic            skid_load;
    logic            skid_valid_next;

    decode_comb #(.XLEN(XLEN)) u_decode (
        .insn   (in_insn),
        .bundle (dec_bundle)
    );

    assign accept    = in_valid && in_ready_q;
    assign main_free = !main_valid || out_ready;

    // Entry steering: a free main entry refills from skid first to keep order, else from input.
    always_comb begin
        main_load       = 1'b0;
        skid_load       = 1'b0;
        skid_valid_next = 1'b0;
        if (!rst && !flush) begin
            skid_valid_next = skid_valid;
            if (main_free) begin
                main_load       = skid_valid || accept;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                skid_load       = 1'b1;
                skid_valid_next = 1'b1;
            end
        end
    end

    // Valid bits, registered in_ready and decoded bundles; reset beats flush beats transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            in_ready_q  <= 1'b0;
            main_bundle <= '0;
            skid_bundle <= '0;
        end else if (flush) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (main_free) main_valid <= main_load;
            skid_valid <= skid_valid_next;
            in_ready_q <= !skid_valid_next;
            if (main_load) main_bundle <= skid_valid ? skid_bundle : dec_bundle;
            if (skid_load) skid_bundle <= dec_bundle;
        end
    end

    // Program counters travel beside the bundles; the main pc is only cleared when asked to be.
    always_ff @(posedge clk) begin
        if (rst && RESET_PC_ZERO) begin
            main_pc <= '0;
        end else if (main_load) begin
            main_pc <= skid_valid ? skid_pc : in_pc;
        end
        if (skid_load) skid_pc <= in_pc;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_pc    = main_pc;
    assign {out_opcode, out_alu_op, out_rd, out_rs1, out_rs2,
            out_illegal, out_uses_rs1, out_uses_rs2, out_writes_rd, out_imm} = main_bundle;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench: XLEN=64 and XLEN=32 stages driven in lockstep against a queue model.
module tb_decode_pipe;

    localparam logic [4:0] LUI     = 5'h0D;
    localparam logic [4:0] AUIPC   = 5'h05;
    localparam logic [4:0] JAL     = 5'h1B;
    localparam logic [4:0] JALR    = 5'h19;
    localparam logic [4:0] BRANCH  = 5'h18;
    localparam logic [4:0] LOAD    = 5'h00;
    localparam logic [4:0] STORE   = 5'h08;
    localparam logic [4:0] OPIMM   = 5'h04;
    localparam logic [4:0] OP      = 5'h0C;
    localparam logic [4:0] OPIMM32 = 5'h06;
    localparam logic [4:0] OP32    = 5'h0E;
    localparam logic [4:0] MISCMEM = 5'h03;
    localparam logic [4:0] SYSTEM  = 5'h1C;

    typedef struct {
        logic [4:0]  opc;
        logic [4:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic        ill;
        logic        u1;
        logic        u2;
        logic        wr;
    } exp_t;

    typedef struct {
        logic [31:0] insn;
        logic [63:0] pc;
    } item_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        rdy64, v64, ill64, u1_64, u2_64, wr64;
    logic [63:0] pc64, imm64;
    logic [4:0]  opc64, alu64, rd64, rs1_64, rs2_64;

    logic        rdy32, v32, ill32, u1_32, u2_32, wr32;
    logic [31:0] pc32, imm32;
    logic [4:0]  opc32, alu32, rd32, rs1_32, rs2_32;

    int    errors = 0;
    int    checks = 0;
    item_t mq[$];
    item_t m_item;
    bit    m_ready = 1'b0;
    bit    m_acc;
    bit    started = 1'b0;

    decode_pipe #(.XLEN(64), .RESET_PC_ZERO(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_pc(pc64),
        .out_opcode(opc64), .out_alu_op(alu64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_imm(imm64), .out_illegal(ill64), .out_uses_rs1(u1_64), .out_uses_rs2(u2_64),
        .out_writes_rd(wr64)
    );

    decode_pipe #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_insn(in_insn), .in_pc(in_pc[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_pc(pc32),
        .out_opcode(opc32), .out_alu_op(alu32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_imm(imm32), .out_illegal(ill32), .out_uses_rs1(u1_32), .out_uses_rs2(u2_32),
        .out_writes_rd(wr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written from the ISA field rules with plain 64-bit arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] insn, input int xlen);
        exp_t        e;
        logic [63:0] w;
        logic [63:0] hi;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          rv64;
        bit          legal;
        bit          st;
        bit          br;
        w     = {32'b0, insn};
        hi    = insn[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
        op    = insn[6:2];
        f3    = insn[14:12];
        f7    = insn[31:25];
        rv64  = (xlen == 64);
        st    = (op == STORE);
        br    = (op == BRANCH);
        case (op)
            LUI, AUIPC:                 e.imm = (hi << 32) | (w & 64'hFFFF_F000);
            JAL:                        e.imm = (hi << 20) | (((w >> 12) & 64'd255) << 12)
                                              | (((w >> 20) & 64'd1) << 11) | (((w >> 21) & 64'd1023) << 1);
            JALR, LOAD, OPIMM, OPIMM32: e.imm = (hi << 11) | ((w >> 20) & 64'd2047);
            BRANCH:                     e.imm = (hi << 12) | (((w >> 7) & 64'd1) << 11)
                                              | (((w >> 25) & 64'd63) << 5) | (((w >> 8) & 64'd15) << 1);
            STORE:                      e.imm = (hi << 11) | (((w >> 25) & 64'd63) << 5) | ((w >> 7) & 64'd31);
            default:                    e.imm = 64'd0;
        endcase
        legal = (insn[1:0] == 2'b11);
        case (op)
            LUI, AUIPC, JAL, MISCMEM, SYSTEM: legal = legal;
            JALR:    if (f3 != 3'd0) legal = 1'b0;
            BRANCH:  if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
            LOAD:    if (f3 == 3'd7 || (!rv64 && (f3 == 3'd3 || f3 == 3'd6))) legal = 1'b0;
            STORE:   if (f3 >= 3'd4 || (!rv64 && f3 == 3'd3)) legal = 1'b0;
            OPIMM:   if (!rv64 && (f3 == 3'd1 || f3 == 3'd5) && insn[25]) legal = 1'b0;
            OP:      if (!(f7 == 7'd0 || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)))) legal = 1'b0;
            OPIMM32, OP32: if (!rv64) legal = 1'b0;
            default: legal = 1'b0;
        endcase
        e.opc = op;
        e.alu = {(op == OPIMM32 || op == OP32),
                 ((op == OP || op == OP32) ||
                  ((op == OPIMM || op == OPIMM32) && (f3 == 3'd1 || f3 == 3'd5))) ? insn[30] : 1'b0,
                 f3};
        e.rd  = (st || br) ? 5'd0 : insn[11:7];
        e.rs1 = insn[19:15];
        e.rs2 = insn[24:20];
        e.ill = !legal;
        e.u1  = legal && !(op == LUI || op == AUIPC || op == JAL);
        e.u2  = legal && (op == OP || op == OP32 || st || br);
        e.wr  = legal && !st && !br && (insn[11:7] != 5'd0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then stop at the following falling edge.
    task automatic applyStimulus(input bit v, input logic [31:0] insn, input logic [63:0] pc,
                                 input bit rdy, input bit fl, input bit rs);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
    endtask

    // Transaction-level model: a FIFO of at most two accepted words.
    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            mq.delete();
            m_ready = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ready = 1'b1;
        end else begin
            m_acc = in_valid && m_ready;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_acc) begin
                m_item.insn = in_insn;
                m_item.pc   = in_pc;
                mq.push_back(m_item);
            end
            m_ready = (mq.size() < 2);
        end
    end

    // Every cycle: handshake signals always, the full bundle whenever the model holds a word.
    always @(negedge clk) begin
        exp_t e64;
        exp_t e32;
        if (started) begin
            checkOutput("in_ready64", 192'(rdy64), 192'(m_ready));
            checkOutput("in_ready32", 192'(rdy32), 192'(m_ready));
            checkOutput("out_valid64", 192'(v64), 192'(mq.size() > 0));
            checkOutput("out_valid32", 192'(v32), 192'(mq.size() > 0));
            if (mq.size() > 0) begin
                e64 = ref_decode(mq[0].insn, 64);
                e32 = ref_decode(mq[0].insn, 32);
                checkOutput("bundle64",
                    192'({opc64, alu64, rd64, rs1_64, rs2_64, ill64, u1_64, u2_64, wr64, imm64, pc64}),
                    192'({e64.opc, e64.alu, e64.rd, e64.rs1, e64.rs2, e64.ill, e64.u1, e64.u2, e64.wr,
                          e64.imm, mq[0].pc}));
                checkOutput("bundle32",
                    192'({opc32, alu32, rd32, rs1_32, rs2_32, ill32, u1_32, u2_32, wr32, imm32, pc32}),
                    192'({e32.opc, e32.alu, e32.rd, e32.rs1, e32.rs2, e32.ill, e32.u1, e32.u2, e32.wr,
                          e32.imm[31:0], mq[0].pc[31:0]}));
            end
        end
    end

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [4:0]  op;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: op = LUI;     1: op = AUIPC;   2: op = JAL;     3: op = JALR;
            4: op = BRANCH;  5: op = LOAD;    6: op = STORE;   7: op = OPIMM;
            8: op = OP;      9: op = OPIMM32; 10: op = OP32;   11: op = MISCMEM;
            12: op = SYSTEM; default: op = r[6:2];
        endcase
        if (k < 13) r[6:0] = {op, 2'b11};
        if ((op == OP || op == OP32) && r[0] && $urandom_range(0, 1) == 1)
            r[31:25] = r[26] ? 7'b0100000 : 7'b0000000;
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b0;

        // Reset held for three edges.
        repeat (3) applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_valid", 192'(v64), 192'(0));
        checkOutput("reset_imm", 192'(imm64), 192'(0));
        checkOutput("reset_ready", 192'(rdy64), 192'(0));
        checkOutput("reset_pc", 192'(pc64), 192'(0));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("ready_after_reset", 192'(rdy64), 192'(1));

        // addi x1, x0, -1
        applyStimulus(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("addi_valid", 192'(v64), 192'(1));
        checkOutput("addi_imm64", 192'(imm64), 192'(64'hFFFF_FFFF_FFFF_FFFF));
        checkOutput("addi_imm32", 192'(imm32), 192'(32'hFFFF_FFFF));
        checkOutput("addi_fields", 192'({rd64, alu64, u1_64, wr64, ill64}),
                    192'({5'd1, 5'b00000, 1'b1, 1'b1, 1'b0}));
        checkOutput("addi_pc", 192'(pc64), 192'(64'h1000));

        // Backpressure: sub then add held in the two entries.
        applyStimulus(1'b1, 32'h40B50533, 64'h2000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00C58633, 64'h2004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ready_low", 192'(rdy64), 192'(0));
        checkOutput("bp_sub", 192'({alu64, rd64}), 192'({5'b01000, 5'd10}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_sub_held", 192'({alu64, rd64, pc64}), 192'({5'b01000, 5'd10, 64'h2000}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_add", 192'({v64, alu64, rd64, pc64}), 192'({1'b1, 5'b00000, 5'd12, 64'h2004}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_drained", 192'(v64), 192'(0));

        // Flush with both entries full and a word offered.
        applyStimulus(1'b1, 32'h00100093, 64'h3000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200113, 64'h3004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00300193, 64'h3008, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_full", 192'({v64, rdy64}), 192'({1'b1, 1'b0}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_empty", 192'({v64, rdy64}), 192'({1'b0, 1'b1}));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_stays_empty", 192'(v64), 192'(0));

        // Flush while in_ready=1 drops the word offered alongside it.
        applyStimulus(1'b1, 32'h00400213, 64'h4000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00500293, 64'h4004, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_drop", 192'(v64), 192'(0));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_drop_later", 192'(v64), 192'(0));

        // addiw: legal word op on RV64, illegal on RV32.
        applyStimulus(1'b1, 32'h0015051B, 64'h5000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("addiw64", 192'({alu64, ill64, wr64}), 192'({5'b10000, 1'b0, 1'b1}));
        checkOutput("addiw32", 192'({ill32, wr32}), 192'({1'b1, 1'b0}));

        applyStimulus(1'b1, 32'h00000000, 64'h5004, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("zero_illegal", 192'({ill64, ill32, u1_64, wr64}), 192'({1'b1, 1'b1, 1'b0, 1'b0}));

        applyStimulus(1'b1, 32'hFE000EE3, 64'h5008, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("beq_imm", 192'(imm64), 192'(64'hFFFF_FFFF_FFFF_FFFC));
        checkOutput("beq_fields", 192'({rd64, u2_64, wr64}), 192'({5'd0, 1'b1, 1'b0}));

        applyStimulus(1'b1, 32'h123450B7, 64'h500C, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("lui_imm64", 192'(imm64), 192'(64'h1234_5000));
        checkOutput("lui_imm32", 192'(imm32), 192'(32'h1234_5000));
        checkOutput("lui_fields", 192'({rd64, u1_64, wr64}), 192'({5'd1, 1'b0, 1'b1}));

        // Randomized traffic with backpressure, occasional flush and rare reset.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_insn(), {$urandom, $urandom},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                          $urandom_range(0, 600) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
